// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter.
// Holds the register-file bus widths, the zero-register address, the reset
// polarity constants and small index helpers used by the arbiter and its
// picker.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;   // register address bus width
  localparam int REG_W      = 32;  // register data bus width

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic                  RST_DISABLE  = 1'b0;
  localparam logic [REG_W-1:0]      ZERO_WORD    = '0;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Combinational rotating-priority picker for two register-file write ports.
// Ports:
//   valid    - per-requester write pending
//   addr     - packed destination registers, slice i belongs to requester i
//   ptr      - requester index that has highest priority this cycle
//   g1_idx/g1_vld - requester granted write port 1
//   g2_idx/g2_vld - requester granted write port 2
//   last_idx - last requester granted in scan order (valid if g1_vld)
module wb_port_arbiter_rr_pick2
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REG_ADDR_W,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      g1_idx,
  output logic               g1_vld,
  output logic [PW-1:0]      g2_idx,
  output logic               g2_vld,
  output logic [PW-1:0]      last_idx
);

  int            scan_i;
  logic [AW-1:0] scan_a;
  logic [AW-1:0] g1_addr;

  // Zero-address requests are not candidates; they never take a port.
  // A candidate matching the port-1 address is skipped so both ports never
  // write the same register in one cycle.
  always_comb begin
    g1_idx  = '0;
    g1_vld  = 1'b0;
    g2_idx  = '0;
    g2_vld  = 1'b0;
    g1_addr = '0;
    scan_i  = 0;
    scan_a  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_i = int'(ptr) + k;
      if (scan_i >= NREQ) scan_i = scan_i - NREQ;
      scan_a = addr[scan_i*AW +: AW];
      if (valid[scan_i] && (scan_a != '0)) begin
        if (!g1_vld) begin
          g1_vld  = 1'b1;
          g1_idx  = PW'(scan_i);
          g1_addr = scan_a;
        end else if (!g2_vld && (scan_a != g1_addr)) begin
          g2_vld = 1'b1;
          g2_idx = PW'(scan_i);
        end
      end
    end
    last_idx = g2_vld ? g2_idx : g1_idx;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register file's two write ports among
// NREQ writeback requesters with rotating priority.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   req_valid/addr/data  - per-requester write requests (packed slices)
//   req_ready            - combinational accept per requester
//   we1/waddr1/wdata1    - registered write port 1
//   we2/waddr2/wdata2    - registered write port 2
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REG_ADDR_W,
  parameter int DW   = REG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               we1,
  output logic [AW-1:0]      waddr1,
  output logic [DW-1:0]      wdata1,
  output logic               we2,
  output logic [AW-1:0]      waddr2,
  output logic [DW-1:0]      wdata2
);

  localparam int PW = idx_w(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] g1_idx;
  logic [PW-1:0] g2_idx;
  logic [PW-1:0] last_idx;
  logic          g1_vld;
  logic          g2_vld;

  wb_port_arbiter_rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW),
    .PW   (PW)
  ) u_pick (
    .valid    (req_valid),
    .addr     (req_addr),
    .ptr      (ptr),
    .g1_idx   (g1_idx),
    .g1_vld   (g1_vld),
    .g2_idx   (g2_idx),
    .g2_vld   (g2_vld),
    .last_idx (last_idx)
  );

  // Zero-register writes are acknowledged at once and dropped; the picker
  // already excludes them, so they never consume a port or move ptr.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (rst == RST_DISABLE) && req_valid[i] &&
                     ((req_addr[i*AW +: AW] == AW'(NOP_REG_ADDR)) ||
                      (g1_vld && (g1_idx == PW'(i))) ||
                      (g2_vld && (g2_idx == PW'(i))));
    end
  end

  // Output stage: accepted writes reach the register file one cycle later.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ptr    <= '0;
      we1    <= 1'b0;
      we2    <= 1'b0;
      waddr1 <= '0;
      waddr2 <= '0;
      wdata1 <= DW'(ZERO_WORD);
      wdata2 <= DW'(ZERO_WORD);
    end else begin
      we1 <= g1_vld;
      we2 <= g2_vld;
      if (g1_vld) begin
        waddr1 <= req_addr[int'(g1_idx)*AW +: AW];
        wdata1 <= req_data[int'(g1_idx)*DW +: DW];
      end
      if (g2_vld) begin
        waddr2 <= req_addr[int'(g2_idx)*AW +: AW];
        wdata2 <= req_data[int'(g2_idx)*DW +: DW];
      end
      if (g1_vld) begin
        ptr <= (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter with a scoreboard of registered
// write-port results plus directed expectations.
module tb_wb_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we1, we2;
  logic [AW-1:0]      waddr1, waddr2;
  logic [DW-1:0]      wdata1, wdata2;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .we2       (we2),
    .waddr2    (waddr2),
    .wdata2    (wdata2)
  );

  typedef struct {
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          we2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    bit            full;  // compare addr/data even when we is low (reset)
  } exp_t;

  exp_t sbq[$];
  int   mptr;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // Reference model: derive expected ready and next-cycle outputs from the
  // current inputs and the model pointer, check ready, push outputs, clock,
  // then pop and compare the registered ports.
  task automatic step(input logic [NREQ-1:0] plan_rdy);
    exp_t           e;
    exp_t           o;
    logic [NREQ-1:0] rdy;
    int             g1, g2, i;
    logic [AW-1:0]  ai;
    #1;
    rdy = '0;
    g1  = -1;
    g2  = -1;
    e   = '{we1: 1'b0, a1: '0, d1: '0, we2: 1'b0, a2: '0, d2: '0, full: 1'b0};
    if (rst) begin
      e.full = 1'b1;
      mptr   = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        i  = (mptr + k) % NREQ;
        ai = req_addr[i*AW +: AW];
        if (req_valid[i]) begin
          if (ai == '0) rdy[i] = 1'b1;
          else if (g1 < 0) begin
            g1 = i; rdy[i] = 1'b1;
          end else if (g2 < 0 && ai != req_addr[g1*AW +: AW]) begin
            g2 = i; rdy[i] = 1'b1;
          end
        end
      end
      if (g1 >= 0) begin
        e.we1 = 1'b1; e.a1 = req_addr[g1*AW +: AW]; e.d1 = req_data[g1*DW +: DW];
      end
      if (g2 >= 0) begin
        e.we2 = 1'b1; e.a2 = req_addr[g2*AW +: AW]; e.d2 = req_data[g2*DW +: DW];
      end
      if (g2 >= 0)      mptr = (g2 + 1) % NREQ;
      else if (g1 >= 0) mptr = (g1 + 1) % NREQ;
    end
    check("ready_model", req_ready, rdy);
    check("ready_plan", req_ready, plan_rdy);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      o = sbq.pop_front();
      check("we1", we1, o.we1);
      check("we2", we2, o.we2);
      if (o.full || o.we1) begin
        check("waddr1", waddr1, o.a1);
        check("wdata1", wdata1, o.d1);
      end
      if (o.full || o.we2) begin
        check("waddr2", waddr2, o.a2);
        check("wdata2", wdata2, o.d2);
      end
    end
  endtask

  // Directed expectations on the registered ports; addr/data only when enabled.
  task automatic plan_out(input string tag, input logic e1, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d1, input logic e2,
                          input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    check({tag, "_we1"}, we1, e1);
    check({tag, "_we2"}, we2, e2);
    if (e1) begin
      check({tag, "_a1"}, waddr1, a1);
      check({tag, "_d1"}, wdata1, d1);
    end
    if (e2) begin
      check({tag, "_a2"}, waddr2, a2);
      check({tag, "_d2"}, wdata2, d2);
    end
  endtask

  initial begin
    mptr      = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset with all requesters valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA000_0000 + i);
    repeat (3) step(4'b0000);
    check("rst_waddr1", waddr1, 0);
    check("rst_wdata2", wdata2, 0);
    rst = 1'b0;
    step(4'b0011);
    plan_out("rel", 1'b1, 5'd1, 32'hA000_0000, 1'b1, 5'd2, 32'hA000_0001);
    step(4'b1100);  // ptr 2 -> 0
    plan_out("rel2", 1'b1, 5'd3, 32'hA000_0002, 1'b1, 5'd4, 32'hA000_0003);

    // Two distinct writes at ptr 0
    clear_reqs();
    set_req(0, 1'b1, 5'd5, 32'h1111_1111);
    set_req(2, 1'b1, 5'd6, 32'h2222_2222);
    step(4'b0101);
    plan_out("dist", 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
    clear_reqs();
    set_req(3, 1'b1, 5'd10, 32'h3333_3333);
    step(4'b1000);  // ptr 3 -> 0
    plan_out("single", 1'b1, 5'd10, 32'h3333_3333, 1'b0, '0, '0);

    // Same-address collision
    clear_reqs();
    set_req(0, 1'b1, 5'd7, 32'hC0C0_0000);
    set_req(1, 1'b1, 5'd7, 32'hC0C0_0001);
    set_req(3, 1'b1, 5'd9, 32'hC0C0_0003);
    step(4'b1001);
    plan_out("coll", 1'b1, 5'd7, 32'hC0C0_0000, 1'b1, 5'd9, 32'hC0C0_0003);
    set_req(0, 1'b0, '0, '0);
    set_req(3, 1'b0, '0, '0);
    step(4'b0010);  // ptr 0 -> 2
    plan_out("coll2", 1'b1, 5'd7, 32'hC0C0_0001, 1'b0, '0, '0);

    // Zero register discard; ptr must stay at 2
    clear_reqs();
    set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step(4'b0010);
    plan_out("zero", 1'b0, '0, '0, 1'b0, '0, '0);
    clear_reqs();
    set_req(0, 1'b1, 5'd20, 32'h0000_0020);
    set_req(2, 1'b1, 5'd22, 32'h0000_0022);
    step(4'b0101);  // scan from 2: req2 port 1, req0 port 2; ptr -> 1
    plan_out("zptr", 1'b1, 5'd22, 32'h0000_0022, 1'b1, 5'd20, 32'h0000_0020);
    clear_reqs();
    set_req(3, 1'b1, 5'd23, 32'h0000_0023);
    step(4'b1000);  // ptr -> 0

    // Rotation with all requesters continuously valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(11 + i), 32'hF000_0000 + i);
    step(4'b0011);
    plan_out("rot0", 1'b1, 5'd11, 32'hF000_0000, 1'b1, 5'd12, 32'hF000_0001);
    step(4'b1100);
    plan_out("rot1", 1'b1, 5'd13, 32'hF000_0002, 1'b1, 5'd14, 32'hF000_0003);
    step(4'b0011);
    plan_out("rot2", 1'b1, 5'd11, 32'hF000_0000, 1'b1, 5'd12, 32'hF000_0001);
    step(4'b1100);  // ptr -> 0, we1 pending on outputs

    // Reset mid-stream with a pending request on req1
    clear_reqs();
    set_req(1, 1'b1, 5'd17, 32'h5151_5151);
    rst = 1'b1;
    step(4'b0000);
    plan_out("mrst", 1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b0;
    step(4'b0010);
    plan_out("post", 1'b1, 5'd17, 32'h5151_5151, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
